// File: rtl/alarm_beeper_pkg.sv
// alarm_beeper_pkg: FSM state type, board-derived timing defaults and a counter-width helper.
package alarm_beeper_pkg;

    typedef enum logic [1:0] {IDLE, BEEP, GAP} state_e;

    localparam int CLK_HZ  = 50_000_000;
    localparam int TONE_HZ = 1_000;

    localparam int TONE_DIV_DEF    = CLK_HZ / (2 * TONE_HZ);
    localparam int BEEP_CYCLES_DEF = CLK_HZ / 4;
    localparam int GAP_CYCLES_DEF  = CLK_HZ / 4;
    localparam int NUM_BEEPS_DEF   = 4;

    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_beeper_if.sv
// alarm_beeper_if: start/stop requests in, buzzer drive and status out.
interface alarm_beeper_if;
    logic start;
    logic stop;
    logic buzzer;
    logic busy;
    logic done;
    modport master (output start, stop, input buzzer, busy, done);
    modport slave  (input start, stop, output buzzer, busy, done);
endinterface

// File: rtl/alarm_beeper_tone_gen.sv
// alarm_beeper_tone_gen: registered square wave, TONE_DIV cycles per half-period, starting high on restart.
module alarm_beeper_tone_gen
    import alarm_beeper_pkg::*;
#(
    parameter int TONE_DIV = TONE_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic restart_i,
    output logic wave_o
);
    localparam int TW = cw(TONE_DIV);
    localparam logic [TW-1:0] LAST = TW'(TONE_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic          wave_q;

    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q  <= '0;
            wave_q <= 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_q  <= '0;
            wave_q <= ~wave_q;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign wave_o = wave_q;
endmodule

// File: rtl/alarm_beeper.sv
// alarm_beeper: turns a start pulse into NUM_BEEPS tone bursts separated by silent gaps.
module alarm_beeper
    import alarm_beeper_pkg::*;
#(
    parameter int TONE_DIV    = TONE_DIV_DEF,
    parameter int BEEP_CYCLES = BEEP_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int NUM_BEEPS   = NUM_BEEPS_DEF
) (
    input  logic clk,
    input  logic rst,
    alarm_beeper_if.slave bus
);
    localparam int DW = cw(BEEP_CYCLES) > cw(GAP_CYCLES) ? cw(BEEP_CYCLES) : cw(GAP_CYCLES);
    localparam int BW = $clog2(NUM_BEEPS + 1);
    localparam logic [DW-1:0] BEEP_LAST = DW'(BEEP_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] NB        = BW'(NUM_BEEPS);

    state_e        state_q;
    logic [DW-1:0] dur_q;
    logic [BW-1:0] burst_q;
    logic          busy_q;
    logic          done_q;
    logic          buzzer;

    logic beep_end, gap_end, tone_restart, tone_en;

    assign beep_end = state_q == BEEP && dur_q == BEEP_LAST;
    assign gap_end  = state_q == GAP && dur_q == GAP_LAST;

    // Tone control follows the state the FSM will hold next cycle, so the buzzer register lines up with it.
    assign tone_restart = !bus.stop && (bus.start || gap_end);
    assign tone_en      = tone_restart || (!bus.stop && state_q == BEEP && !beep_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dur_q   <= '0;
            burst_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state_q <= IDLE;
                dur_q   <= '0;
                burst_q <= '0;
                busy_q  <= 1'b0;
            end else if (bus.start) begin
                state_q <= BEEP;
                dur_q   <= '0;
                burst_q <= BW'(1);
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    BEEP: begin
                        dur_q <= beep_end ? '0 : dur_q + DW'(1);
                        if (beep_end && burst_q < NB) begin
                            state_q <= GAP;
                        end else if (beep_end) begin
                            state_q <= IDLE;
                            burst_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    GAP: begin
                        dur_q <= gap_end ? '0 : dur_q + DW'(1);
                        if (gap_end) begin
                            state_q <= BEEP;
                            burst_q <= burst_q + BW'(1);
                        end
                    end
                    default: begin
                        dur_q   <= '0;
                        burst_q <= '0;
                    end
                endcase
            end
        end
    end

    alarm_beeper_tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (tone_en),
        .restart_i (tone_restart),
        .wave_o    (buzzer)
    );

    assign bus.buzzer = buzzer;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
